// File: rtl/icache.sv
// Direct-mapped instruction cache: 2^IDX_W lines of 16 B, single outstanding line refill.
// Define ICACHE_FWD_EN to forward the requested word on the refill edge instead of re-looking it up.
module icache #(
  parameter int IDX_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         rb,
  input  logic         if_valid,
  input  logic [31:0]  if_pc,
  output logic         if_hit,
  output logic [31:0]  if_inst,
  output logic         mc_fc_valid,
  output logic [31:0]  mc_fc_addr,
  input  logic         mc_fc_done,
  input  logic [127:0] mc_fc_line,
  output logic         dbg_state
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              if_hit_q, if_hit_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic              mc_fc_valid_q, mc_fc_valid_d;
  logic [31:0]       mc_fc_addr_q, mc_fc_addr_d;
  logic [31:2]       pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              line_we;

  logic [127:0]      data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];

  logic [IDX_W-1:0]  look_idx;
  logic [TAG_W-1:0]  look_tag;
  logic              look_hit;
  logic [IDX_W-1:0]  fill_idx;
  logic [127:0]      look_line;

  function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] off);
    logic [31:0] w;
    case (off)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

  assign look_idx  = if_pc[IDX_W+3:4];
  assign look_tag  = if_pc[31:IDX_W+4];
  assign look_line = data_q[look_idx];
  assign look_hit  = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign fill_idx  = pc_q[IDX_W+3:4];

  // Handshake: a request is taken only in IDLE with if_valid=1, rb=0 and no response
  // pulse outstanding; the response is a single if_hit pulse. mc_fc_valid rises on a miss
  // and stays high with a stable address until the mc_fc_done pulse completes the refill.
  always_comb begin
    state_d       = state_q;
    if_hit_d      = if_hit_q;
    if_inst_d     = if_inst_q;
    mc_fc_valid_d = mc_fc_valid_q;
    mc_fc_addr_d  = mc_fc_addr_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    valid_d       = valid_q;
    line_we       = 1'b0;

    if (rdy) begin
      if_hit_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (if_valid && !rb && !if_hit_q) begin
            if (look_hit) begin
              if_hit_d  = 1'b1;
              if_inst_d = word_sel(look_line, if_pc[3:2]);
            end else begin
              pc_d          = if_pc[31:2];
              mc_fc_valid_d = 1'b1;
              mc_fc_addr_d  = {if_pc[31:4], 4'h0};
              state_d       = WAIT;
            end
          end
        end
        WAIT: begin
          if (rb) drop_d = 1'b1;
          if (mc_fc_done) begin
            line_we           = 1'b1;
            valid_d[fill_idx] = 1'b1;
            mc_fc_valid_d     = 1'b0;
            drop_d            = 1'b0;
            state_d           = IDLE;
`ifdef ICACHE_FWD_EN
            if (!drop_q && !rb) begin
              if_hit_d  = 1'b1;
              if_inst_d = word_sel(mc_fc_line, pc_q[3:2]);
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      if_hit_q      <= 1'b0;
      if_inst_q     <= 32'h0;
      mc_fc_valid_q <= 1'b0;
      mc_fc_addr_q  <= 32'h0;
      pc_q          <= '0;
      drop_q        <= 1'b0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      if_hit_q      <= if_hit_d;
      if_inst_q     <= if_inst_d;
      mc_fc_valid_q <= mc_fc_valid_d;
      mc_fc_addr_q  <= mc_fc_addr_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      valid_q       <= valid_d;
    end
  end

  // Line storage needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (line_we && !rst) begin
      data_q[fill_idx] <= mc_fc_line;
      tag_q[fill_idx]  <= pc_q[31:IDX_W+4];
    end
  end

  // A pulse held across a freeze must not be seen while frozen.
  assign if_hit      = if_hit_q & rdy;
  assign if_inst     = if_inst_q;
  assign mc_fc_valid = mc_fc_valid_q;
  assign mc_fc_addr  = mc_fc_addr_q;
  assign dbg_state   = (state_q == WAIT);

  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, if_pc[1:0]};

endmodule
